// File: rtl/hsv2rgb.sv
// HSV to RGB converter: 8-bit hue circle (0..255), saturation and value in,
// DWIDTH_RGB-bit channels out through a stall-able 4-stage pipeline.
module hsv2rgb #(
    parameter int DWIDTH_RGB = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            h,
    input  logic [7:0]            s,
    input  logic [7:0]            v,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DWIDTH_RGB-1:0] r,
    output logic [DWIDTH_RGB-1:0] g,
    output logic [DWIDTH_RGB-1:0] b
);

    logic        w_en;
    logic [10:0] w_h6;
    logic [15:0] w_sf_prod;
    logic [15:0] w_sfi_prod;
    logic [15:0] w_p_prod;
    logic [15:0] w_q_prod;
    logic [15:0] w_t_prod;
    logic [23:0] w_rgb;

    logic        r_s1_valid;
    logic [7:0]  r_s1_h;
    logic [7:0]  r_s1_s;
    logic [7:0]  r_s1_v;

    logic        r_s2_valid;
    logic [2:0]  r_s2_sector;
    logic [7:0]  r_s2_f;
    logic [7:0]  r_s2_s;
    logic [7:0]  r_s2_v;

    logic        r_s3_valid;
    logic [2:0]  r_s3_sector;
    logic [7:0]  r_s3_sf;
    logic [7:0]  r_s3_sfi;
    logic [7:0]  r_s3_s;
    logic [7:0]  r_s3_v;

    logic        r_s4_valid;
    logic [2:0]  r_s4_sector;
    logic [7:0]  r_s4_p;
    logic [7:0]  r_s4_q;
    logic [7:0]  r_s4_t;
    logic [7:0]  r_s4_s;
    logic [7:0]  r_s4_v;

    // One global enable: the whole pipe freezes while the output is held.
    assign w_en     = out_ready | ~out_valid;
    assign in_ready = w_en;

    assign w_h6       = {3'b000, r_s1_h} * 11'd6;
    assign w_sf_prod  = {8'd0, r_s2_s} * {8'd0, r_s2_f};
    assign w_sfi_prod = {8'd0, r_s2_s} * {8'd0, 8'd255 - r_s2_f};
    assign w_p_prod   = {8'd0, r_s3_v} * {8'd0, 8'd255 - r_s3_s};
    assign w_q_prod   = {8'd0, r_s3_v} * {8'd0, 8'd255 - r_s3_sf};
    assign w_t_prod   = {8'd0, r_s3_v} * {8'd0, 8'd255 - r_s3_sfi};

    // Sector select; greys and black override the hue path.
    always_comb begin
        w_rgb = 24'd0;
        if (r_s4_s == 8'd0) begin
            w_rgb = {r_s4_v, r_s4_v, r_s4_v};
        end else if (r_s4_v == 8'd0) begin
            w_rgb = 24'd0;
        end else begin
            case (r_s4_sector)
                3'd0:    w_rgb = {r_s4_v, r_s4_t, r_s4_p};
                3'd1:    w_rgb = {r_s4_q, r_s4_v, r_s4_p};
                3'd2:    w_rgb = {r_s4_p, r_s4_v, r_s4_t};
                3'd3:    w_rgb = {r_s4_p, r_s4_q, r_s4_v};
                3'd4:    w_rgb = {r_s4_t, r_s4_p, r_s4_v};
                3'd5:    w_rgb = {r_s4_v, r_s4_p, r_s4_q};
                default: w_rgb = {r_s4_v, r_s4_v, r_s4_v};
            endcase
        end
    end

    // Pipeline registers with synchronous active-low reset and global stall.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_h      <= 8'd0;
            r_s1_s      <= 8'd0;
            r_s1_v      <= 8'd0;
            r_s2_valid  <= 1'b0;
            r_s2_sector <= 3'd0;
            r_s2_f      <= 8'd0;
            r_s2_s      <= 8'd0;
            r_s2_v      <= 8'd0;
            r_s3_valid  <= 1'b0;
            r_s3_sector <= 3'd0;
            r_s3_sf     <= 8'd0;
            r_s3_sfi    <= 8'd0;
            r_s3_s      <= 8'd0;
            r_s3_v      <= 8'd0;
            r_s4_valid  <= 1'b0;
            r_s4_sector <= 3'd0;
            r_s4_p      <= 8'd0;
            r_s4_q      <= 8'd0;
            r_s4_t      <= 8'd0;
            r_s4_s      <= 8'd0;
            r_s4_v      <= 8'd0;
            out_valid   <= 1'b0;
            r           <= {DWIDTH_RGB{1'b0}};
            g           <= {DWIDTH_RGB{1'b0}};
            b           <= {DWIDTH_RGB{1'b0}};
        end else if (w_en) begin
            r_s1_valid  <= in_valid;
            r_s1_h      <= h;
            r_s1_s      <= s;
            r_s1_v      <= v;

            r_s2_valid  <= r_s1_valid;
            r_s2_sector <= w_h6[10:8];
            r_s2_f      <= w_h6[7:0];
            r_s2_s      <= r_s1_s;
            r_s2_v      <= r_s1_v;

            r_s3_valid  <= r_s2_valid;
            r_s3_sector <= r_s2_sector;
            r_s3_sf     <= 8'(w_sf_prod >> 8);
            r_s3_sfi    <= 8'(w_sfi_prod >> 8);
            r_s3_s      <= r_s2_s;
            r_s3_v      <= r_s2_v;

            r_s4_valid  <= r_s3_valid;
            r_s4_sector <= r_s3_sector;
            r_s4_p      <= 8'(w_p_prod >> 8);
            r_s4_q      <= 8'(w_q_prod >> 8);
            r_s4_t      <= 8'(w_t_prod >> 8);
            r_s4_s      <= r_s3_s;
            r_s4_v      <= r_s3_v;

            out_valid   <= r_s4_valid;
            r           <= w_rgb[23 -: DWIDTH_RGB];
            g           <= w_rgb[15 -: DWIDTH_RGB];
            b           <= w_rgb[7 -: DWIDTH_RGB];
        end else begin
            out_valid   <= out_valid;
        end
    end

endmodule

// File: tb/tb_hsv2rgb.sv
// Scoreboard bench for hsv2rgb: directed colour points, stall and reset
// scenarios, then a randomized stream checked against an arithmetic model.
module tb_hsv2rgb;

    localparam int DW = 8;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    h;
    logic [7:0]    s;
    logic [7:0]    v;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] r;
    logic [DW-1:0] g;
    logic [DW-1:0] b;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [23:0] exp_q[$];

    hsv2rgb #(.DWIDTH_RGB(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .h         (h),
        .s         (s),
        .v         (v),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .g         (g),
        .b         (b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Textbook HSV->RGB on the 0..255 hue circle, using integer arithmetic.
    function automatic logic [23:0] ref_rgb(input int hh, input int ss, input int vv);
        int h6, sec, f, sf, sfi, p, q, t, rr, gg, bb;
        if (ss == 0) return {8'(vv), 8'(vv), 8'(vv)};
        if (vv == 0) return 24'd0;
        h6  = hh * 6;
        sec = h6 / 256;
        f   = h6 % 256;
        sf  = (ss * f) / 256;
        sfi = (ss * (255 - f)) / 256;
        p   = (vv * (255 - ss)) / 256;
        q   = (vv * (255 - sf)) / 256;
        t   = (vv * (255 - sfi)) / 256;
        case (sec)
            0:       begin rr = vv; gg = t;  bb = p;  end
            1:       begin rr = q;  gg = vv; bb = p;  end
            2:       begin rr = p;  gg = vv; bb = t;  end
            3:       begin rr = p;  gg = q;  bb = vv; end
            4:       begin rr = t;  gg = p;  bb = vv; end
            default: begin rr = vv; gg = p;  bb = q;  end
        endcase
        return {8'(rr), 8'(gg), 8'(bb)};
    endfunction

    function automatic logic [3*DW-1:0] scale(input logic [23:0] e);
        return {e[23 -: DW], e[15 -: DW], e[7 -: DW]};
    endfunction

    // Holds in_valid until the pixel is taken, then records its expected colour.
    task automatic drive_pixel(input logic [7:0] hh, input logic [7:0] ss,
                               input logic [7:0] vv, input logic [23:0] e);
        bit taken = 1'b0;
        h = hh; s = ss; v = vv; in_valid = 1'b1;
        for (int k = 0; k < 50 && !taken; k++) begin
            @(negedge clock);
            if (in_ready) begin
                exp_q.push_back(e);
                taken = 1'b1;
            end
            @(posedge clock); #1;
        end
        if (!taken) check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    // Counts edges from acceptance until out_valid rises.
    task automatic timed_pixel(input string name, input logic [7:0] hh, input logic [7:0] ss,
                               input logic [7:0] vv, input logic [23:0] e);
        int k = 0;
        drive_pixel(hh, ss, vv, e);
        while (!out_valid && k < 20) begin
            @(posedge clock); #1;
            k++;
        end
        check(name, 32'(k), 32'd4);
    endtask

    // Monitor: pops the scoreboard on each transfer and checks stall stability.
    initial begin
        logic        hold = 1'b0;
        logic [23:0] held = 24'd0;
        logic [23:0] e;
        forever begin
            @(negedge clock);
            check("in_ready_rule", {31'd0, in_ready}, {31'd0, out_ready | ~out_valid});
            if (!reset) begin
                hold = 1'b0;
            end else begin
                if (hold) check("stall_stable", {7'd0, out_valid, 24'({r, g, b})}, {7'd0, 1'b1, held});
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("pixel_rgb", 32'({r, g, b}), 32'(scale(e)));
                    end
                end
                hold = out_valid && !out_ready;
                held = 24'({r, g, b});
            end
        end
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        h = 8'd0; s = 8'd0; v = 8'd0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_rgb", 32'({r, g, b}), 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b1;

        timed_pixel("latency_red", 8'd0, 8'd255, 8'd255, {8'd255, 8'd0, 8'd0});
        timed_pixel("latency_green", 8'd85, 8'd255, 8'd255, {8'd1, 8'd255, 8'd0});
        timed_pixel("latency_blue", 8'd170, 8'd255, 8'd255, {8'd0, 8'd3, 8'd255});
        timed_pixel("latency_grey", 8'd37, 8'd0, 8'd200, {8'd200, 8'd200, 8'd200});
        timed_pixel("latency_black", 8'd99, 8'd180, 8'd0, {8'd0, 8'd0, 8'd0});
        timed_pixel("latency_h255", 8'd255, 8'd255, 8'd255, {8'd255, 8'd0, 8'd5});
        repeat (3) @(posedge clock);
        #1;

        // Six back-to-back pixels with out_ready dropped for three cycles.
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    int hh = 40 * i;
                    drive_pixel(8'(hh), 8'd200, 8'd180, ref_rgb(hh, 200, 180));
                end
            end
            begin
                repeat (4) @(posedge clock);
                #1 out_ready = 1'b0;
                repeat (2) @(posedge clock);
                @(negedge clock);
                check("stall_in_ready", {30'd0, in_ready, out_valid}, {30'd0, 1'b0, 1'b1});
                @(posedge clock);
                #1 out_ready = 1'b1;
            end
        join
        repeat (8) @(posedge clock);
        #1;

        // Reset with three pixels in flight; none of them may emerge.
        for (int i = 0; i < 3; i++) drive_pixel(8'(60 + i), 8'd255, 8'd255, 24'd0);
        reset = 1'b0; in_valid = 1'b1; h = 8'd10; s = 8'd10; v = 8'd10;
        @(posedge clock); #1;
        check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        check("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.delete();
        reset = 1'b1; in_valid = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        timed_pixel("latency_after_reset", 8'd128, 8'd255, 8'd255, ref_rgb(128, 255, 255));

        // Random stream with random gaps and random back-pressure.
        for (int i = 0; i < 600; i++) begin
            int sel = $urandom_range(0, 9);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 4) != 0);
            h = 8'($urandom_range(0, 255));
            s = (sel == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            v = (sel == 1) ? 8'd0 : 8'($urandom_range(0, 255));
            if (sel == 2) h = 8'd255;
            @(negedge clock);
            if (in_valid && in_ready) exp_q.push_back(ref_rgb(int'(h), int'(s), int'(v)));
            @(posedge clock); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
            @(posedge clock); #1;
        end
        repeat (2) @(posedge clock);
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
